int_ctrl18: RTL

- Parametrised interrupt controller that drives the Core18 VECTOR input from up to 15 external interrupt sources.
- Generalises the single fixed VECTOR line with per-channel pending, mask and edge/level mode registers, fixed priority, and a software-trigger register.
- Registers are accessed over the Core18 port bus (PORT_RD/PORT_WR/ADRS/DATAOUT). It sits beside Core18 in the Proc18 top level.

---
 rtl/int_ctrl18_if.sv | 12 +
 rtl/int_ctrl18.sv | 109 ++++++++++
 2 files changed

// File: rtl/int_ctrl18_if.sv
// Core18 port-bus bundle: strobes, address and data between the CPU (master)
// and a port-mapped peripheral (slave).
interface int_ctrl18_if;
    logic        PORT_WR;
    logic        PORT_RD;
    logic [17:0] ADRS;
    logic [17:0] WDATA;
    logic [17:0] RDATA;

    modport master (output PORT_WR, output PORT_RD, output ADRS, output WDATA, input RDATA);
    modport slave  (input PORT_WR, input PORT_RD, input ADRS, input WDATA, output RDATA);
endinterface

// File: rtl/int_ctrl18.sv
// Fixed-priority interrupt controller feeding the Core18 VECTOR input: synchronised
// requests, per-channel pending/mask/edge-level mode, software set, registered vector.
module int_ctrl18 #(
    parameter int          N_CHAN      = 8,
    parameter logic [17:0] BASE_ADRS   = 18'o000700,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [N_CHAN-1:0] IRQ,
    int_ctrl18_if.slave       bus,
    output logic [3:0]        VECTOR,
    output logic              ACTIVE
);

    typedef enum logic [2:0] {
        OFF_PEND = 3'd0,
        OFF_MASK = 3'd1,
        OFF_MODE = 3'd2,
        OFF_SET  = 3'd3,
        OFF_CUR  = 3'd4
    } reg_off_e;

    logic [SYNC_STAGES-1:0][N_CHAN-1:0] sync_q;
    logic [N_CHAN-1:0] edge_q, pend_q, mask_q, mode_q;
    logic [N_CHAN-1:0] pend_d, mask_d, mode_d;
    logic [3:0]        vector_q, vector_d;
    logic              active_q, active_d;

    logic [N_CHAN-1:0] sync_s, rise, set_bits, clr_bits, req, wr_bits;
    logic [17:0]       offset;
    logic              hit;
    reg_off_e          sel;
    logic              unused_wdata;

    // Subtracting the base lets one unsigned compare cover the 5-word window.
    assign offset   = bus.ADRS - BASE_ADRS;
    assign hit      = (offset < 18'd5);
    assign sel      = reg_off_e'(offset[2:0]);
    assign wr_bits  = bus.WDATA[N_CHAN-1:0];
    assign set_bits = (bus.PORT_WR && hit && sel == OFF_SET)  ? wr_bits : '0;
    assign clr_bits = (bus.PORT_WR && hit && sel == OFF_PEND) ? wr_bits : '0;
    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign rise     = sync_s & ~edge_q;
    assign req      = pend_q & mask_q;
    assign unused_wdata = ^bus.WDATA;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pend_d   = pend_q;
        mask_d   = mask_q;
        mode_d   = mode_q;
        vector_d = 4'd0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (mode_q[i])
                pend_d[i] = rise[i] | set_bits[i] | (pend_q[i] & ~clr_bits[i]);
            else
                pend_d[i] = sync_s[i] | set_bits[i];
        end
        if (bus.PORT_WR && hit && sel == OFF_MASK) mask_d = wr_bits;
        if (bus.PORT_WR && hit && sel == OFF_MODE) mode_d = wr_bits;
        // Scan downwards so the lowest requesting channel is the last to assign.
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (req[i]) vector_d = 4'(i + 1);
        end
        active_d = |req;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            sync_q   <= '0;
            edge_q   <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            mode_q   <= '0;
            vector_q <= 4'd0;
            active_q <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1)
                sync_q <= {sync_q[SYNC_STAGES-2:0], IRQ};
            else
                sync_q <= IRQ;
            edge_q   <= sync_s;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            vector_q <= vector_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        bus.RDATA = 18'd0;
        if (bus.PORT_RD && hit) begin
            case (sel)
                OFF_PEND: bus.RDATA = 18'(pend_q);
                OFF_MASK: bus.RDATA = 18'(mask_q);
                OFF_MODE: bus.RDATA = 18'(mode_q);
                OFF_CUR:  bus.RDATA = 18'(vector_q);
                default:  bus.RDATA = 18'd0;
            endcase
        end
    end

    assign VECTOR = vector_q;
    assign ACTIVE = active_q;

endmodule
